// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller:
// forwarding codes, multi-cycle latency floor and the scoreboard entry.
package mips_pipe_pkg;

    // Scoreboard address field is sized for the widest register file we build.
    localparam int SB_AW      = 8;
    localparam int MC_LAT_MIN = 2;

    typedef enum logic [1:0] {
        FWD_RF      = 2'd0,
        FWD_EXE_ALU = 2'd1,
        FWD_MEM_ALU = 2'd2,
        FWD_MEM_LD  = 2'd3
    } fwd_e;

    typedef struct packed {
        logic             valid;
        logic             wen;
        logic [SB_AW-1:0] waddr;
        logic             is_load;
    } sb_entry_t;

    function automatic logic sb_writes(sb_entry_t e, logic [SB_AW-1:0] addr);
        return e.valid && e.wen && (e.waddr == addr);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand source match against the EXE/MEM scoreboard entries; yields the
// forwarding select and whether the operand waits on a load still in EXE.
module fwd_sel
    import mips_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] src_addr_i,
    input  logic              src_used_i,
    input  sb_entry_t         exe_i,
    input  sb_entry_t         mem_i,
    output logic [1:0]        fwd_o,
    output logic              load_use_o
);
    logic [SB_AW-1:0] addr;
    logic             live, hit_exe, hit_mem;

    always_comb begin
        addr    = SB_AW'(src_addr_i);
        // r0 is hard-wired, so it never depends on an in-flight write
        live    = id_valid_i && src_used_i && (src_addr_i != '0);
        hit_exe = live && sb_writes(exe_i, addr);
        hit_mem = live && sb_writes(mem_i, addr);
        fwd_o   = FWD_RF;
        if (hit_exe)      fwd_o = FWD_EXE_ALU;
        else if (hit_mem) fwd_o = mem_i.is_load ? FWD_MEM_LD : FWD_MEM_ALU;
        load_use_o = hit_exe && exe_i.is_load;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// MIPS 5-stage hazard controller: operand forwarding, load-use and multi-cycle
// stalls, optional branch flush, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MC_LAT     = 4,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              id_wen,
    input  logic [REG_AW-1:0] id_waddr,
    input  logic              id_is_load,
    input  logic              id_is_mc,
    input  logic              id_is_branch,
    input  logic              branch_taken,
    output logic              if_en,
    output logic              id_en,
    output logic              exe_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic              id_rst,
    output logic              exe_rst,
    output logic              mem_rst,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int LAT = (MC_LAT < MC_LAT_MIN) ? MC_LAT_MIN : MC_LAT;
    localparam int BW  = $clog2(LAT);

    sb_entry_t        exe_q, exe_d, mem_q, mem_d, wb_q, wb_d;
    logic [BW-1:0]    busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fwd_rs, fwd_rt;
    logic             lu_rs, lu_rt, busy, load_use, flush;
    logic             unused_ok;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs (
        .id_valid_i (id_valid),
        .src_addr_i (rs_addr),
        .src_used_i (rs_used),
        .exe_i      (exe_q),
        .mem_i      (mem_q),
        .fwd_o      (fwd_rs),
        .load_use_o (lu_rs)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_rt (
        .id_valid_i (id_valid),
        .src_addr_i (rt_addr),
        .src_used_i (rt_used),
        .exe_i      (exe_q),
        .mem_i      (mem_q),
        .fwd_o      (fwd_rt),
        .load_use_o (lu_rt)
    );

    // Hazard priority: multi-cycle busy, then load-use, then branch flush.
    always_comb begin
        busy     = (busy_q != '0);
        load_use = lu_rs || lu_rt;
        flush    = (DELAY_SLOT == 0) && id_valid && branch_taken;
        if_en    = 1'b1;
        id_en    = 1'b1;
        exe_en   = 1'b1;
        mem_en   = 1'b1;
        wb_en    = 1'b1;
        id_rst   = 1'b0;
        exe_rst  = 1'b0;
        mem_rst  = 1'b0;
        fwd_a    = fwd_rs;
        fwd_b    = fwd_rt;
        if (!rst) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_en  = 1'b0;
            mem_en  = 1'b0;
            wb_en   = 1'b0;
            id_rst  = 1'b1;
            exe_rst = 1'b1;
            mem_rst = 1'b1;
            fwd_a   = FWD_RF;
            fwd_b   = FWD_RF;
        end else if (busy) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_en  = 1'b0;
            mem_rst = 1'b1;
        end else if (load_use) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_rst = 1'b1;
        end else if (flush) begin
            id_rst  = 1'b1;
        end
    end

    always_comb begin
        exe_d  = exe_q;
        mem_d  = mem_q;
        wb_d   = wb_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (exe_rst)     exe_d = '0;
        else if (exe_en) exe_d = sb_entry_t'{valid: id_valid, wen: id_wen,
                                             waddr: SB_AW'(id_waddr), is_load: id_is_load};
        if (mem_rst)     mem_d = '0;
        else if (mem_en) mem_d = exe_q;
        if (wb_en)       wb_d  = mem_q;
        // The op's first EXE cycle is already spent when the counter loads.
        if (busy)        busy_d = busy_q - BW'(1);
        else if (exe_en && !exe_rst && id_valid && id_is_mc) busy_d = BW'(LAT - 1);
        if (!if_en && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exe_q  <= '0;
            mem_q  <= '0;
            wb_q   <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            exe_q  <= exe_d;
            mem_q  <= mem_d;
            wb_q   <= wb_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;
    // WB tracks retirement only; branch source use is resolved outside this block.
    assign unused_ok = ^{wb_q, id_is_branch};
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: one DUT per DELAY_SLOT setting, a pipeline-occupancy model
// pushing expected outputs per cycle, and a negedge monitor that pops/compares.
module tb_pipe_hazard_ctrl;
    localparam int AW  = 5;
    localparam int LAT = 4;
    localparam bit Y   = 1'b1;
    localparam bit N   = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, id_valid, rs_used, rt_used, id_wen, id_is_load, id_is_mc;
    logic          id_is_branch, branch_taken;
    logic [AW-1:0] rs_addr, rt_addr, id_waddr;

    logic        d1_if_en, d1_id_en, d1_exe_en, d1_mem_en, d1_wb_en, d1_id_rst, d1_exe_rst, d1_mem_rst;
    logic [1:0]  d1_fwd_a, d1_fwd_b;
    logic [31:0] d1_stall_cnt;
    logic        d0_if_en, d0_id_en, d0_exe_en, d0_mem_en, d0_wb_en, d0_id_rst, d0_exe_rst, d0_mem_rst;
    logic [1:0]  d0_fwd_a, d0_fwd_b;
    logic [31:0] d0_stall_cnt;

    pipe_hazard_ctrl #(.REG_AW(AW), .MC_LAT(LAT), .DELAY_SLOT(1), .CNT_W(32)) u_ds1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_used(rs_used), .rt_used(rt_used), .id_wen(id_wen), .id_waddr(id_waddr),
        .id_is_load(id_is_load), .id_is_mc(id_is_mc), .id_is_branch(id_is_branch),
        .branch_taken(branch_taken), .if_en(d1_if_en), .id_en(d1_id_en), .exe_en(d1_exe_en),
        .mem_en(d1_mem_en), .wb_en(d1_wb_en), .id_rst(d1_id_rst), .exe_rst(d1_exe_rst),
        .mem_rst(d1_mem_rst), .fwd_a(d1_fwd_a), .fwd_b(d1_fwd_b), .stall_cnt(d1_stall_cnt));

    pipe_hazard_ctrl #(.REG_AW(AW), .MC_LAT(LAT), .DELAY_SLOT(0), .CNT_W(32)) u_ds0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_used(rs_used), .rt_used(rt_used), .id_wen(id_wen), .id_waddr(id_waddr),
        .id_is_load(id_is_load), .id_is_mc(id_is_mc), .id_is_branch(id_is_branch),
        .branch_taken(branch_taken), .if_en(d0_if_en), .id_en(d0_id_en), .exe_en(d0_exe_en),
        .mem_en(d0_mem_en), .wb_en(d0_wb_en), .id_rst(d0_id_rst), .exe_rst(d0_exe_rst),
        .mem_rst(d0_mem_rst), .fwd_a(d0_fwd_a), .fwd_b(d0_fwd_b), .stall_cnt(d0_stall_cnt));

    typedef struct packed {
        bit v; bit [4:0] rs; bit rsu; bit [4:0] rt; bit rtu;
        bit wen; bit [4:0] wd; bit ld; bit mc; bit bt;
    } stim_t;

    // In-flight instruction as the model sees it: age = cycles already spent in EXE.
    typedef struct packed { bit v; bit w; bit ld; bit mc; int rd; int age; } ins_t;

    typedef struct packed {
        logic [11:0] o1; logic [11:0] o0; logic [31:0] cnt; bit mcb; bit lu; bit ife;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    ins_t        m_pipe[2];        // [0] = EXE, [1] = MEM
    logic [31:0] m_cnt = '0;
    stim_t       cur_s;
    logic        cur_r;
    exp_t        cur_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_no = 0;

    function automatic stim_t mk(bit v, int rs, bit rsu, int rt, bit rtu, bit wen, int wd,
                                 bit ld, bit mc, bit bt);
        stim_t s;
        s.v = v; s.rs = 5'(rs); s.rsu = rsu; s.rt = 5'(rt); s.rtu = rtu;
        s.wen = wen; s.wd = 5'(wd); s.ld = ld; s.mc = mc; s.bt = bt;
        return s;
    endfunction

    function automatic logic [11:0] pack(bit ie, bit de, bit xe, bit me, bit we,
                                         bit ir, bit xr, bit mr, int fa, int fb);
        return {ie, de, xe, me, we, ir, xr, mr, 2'(fa), 2'(fb)};
    endfunction

    // Youngest in-flight writer of the register wins; MEM-stage loads return data.
    function automatic int src_code(bit v, bit used, int a);
        if (!v || !used || a == 0) return 0;
        if (m_pipe[0].v && m_pipe[0].w && m_pipe[0].rd == a) return 1;
        if (m_pipe[1].v && m_pipe[1].w && m_pipe[1].rd == a) return m_pipe[1].ld ? 3 : 2;
        return 0;
    endfunction

    function automatic exp_t model_eval(logic r, stim_t s);
        exp_t e;
        int   fa, fb;
        bit   ife, exe, fl;
        fa    = src_code(s.v, s.rsu, int'(s.rs));
        fb    = src_code(s.v, s.rtu, int'(s.rt));
        e.mcb = m_pipe[0].v && m_pipe[0].mc && (m_pipe[0].age < LAT - 1);
        e.lu  = !e.mcb && (fa == 1 || fb == 1) && m_pipe[0].ld;
        fl    = !e.mcb && !e.lu && s.v && s.bt;
        ife   = !(e.mcb || e.lu);
        exe   = !e.mcb;
        e.ife = ife;
        if (!r) begin
            e.o1 = pack(N, N, N, N, N, Y, Y, Y, 0, 0);
            e.o0 = e.o1;
        end else begin
            e.o1 = pack(ife, ife, exe, Y, Y, N, e.lu, e.mcb, fa, fb);
            e.o0 = pack(ife, ife, exe, Y, Y, fl, e.lu, e.mcb, fa, fb);
        end
        e.cnt = m_cnt;
        return e;
    endfunction

    task automatic model_update(logic r, stim_t s, exp_t e);
        ins_t nw;
        if (!r) begin
            m_pipe[0] = '0; m_pipe[1] = '0; m_cnt = '0;
            return;
        end
        if (!e.ife && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (e.mcb) begin
            m_pipe[1] = '0;
            m_pipe[0].age = m_pipe[0].age + 1;
        end else begin
            m_pipe[1] = m_pipe[0];
            if (e.lu) m_pipe[0] = '0;
            else begin
                nw.v = s.v; nw.w = s.wen; nw.ld = s.ld; nw.mc = s.v && s.mc;
                nw.rd = int'(s.wd); nw.age = 0;
                m_pipe[0] = nw;
            end
        end
    endtask

    task automatic drive(input logic r, input stim_t s);
        rst = r; id_valid = s.v; rs_addr = s.rs; rs_used = s.rsu; rt_addr = s.rt;
        rt_used = s.rtu; id_wen = s.wen; id_waddr = s.wd; id_is_load = s.ld;
        id_is_mc = s.mc; id_is_branch = s.bt; branch_taken = s.bt;
        cur_r = r; cur_s = s;
        cur_e = model_eval(r, s);
        q.push_back(cur_e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update(cur_r, cur_s, cur_e);
        #1;
    endtask

    task automatic cyc(input logic r, input stim_t s);
        drive(r, s);
        tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            cyc_no++;
            n_cmp++;
            if ({d1_if_en, d1_id_en, d1_exe_en, d1_mem_en, d1_wb_en, d1_id_rst, d1_exe_rst,
                 d1_mem_rst, d1_fwd_a, d1_fwd_b} !== mon_e.o1) begin
                n_bad++;
                $display("FAIL out_ds1 cyc=%0d got=%b want=%b", cyc_no,
                         {d1_if_en, d1_id_en, d1_exe_en, d1_mem_en, d1_wb_en, d1_id_rst,
                          d1_exe_rst, d1_mem_rst, d1_fwd_a, d1_fwd_b}, mon_e.o1);
            end
            n_cmp++;
            if ({d0_if_en, d0_id_en, d0_exe_en, d0_mem_en, d0_wb_en, d0_id_rst, d0_exe_rst,
                 d0_mem_rst, d0_fwd_a, d0_fwd_b} !== mon_e.o0) begin
                n_bad++;
                $display("FAIL out_ds0 cyc=%0d got=%b want=%b", cyc_no,
                         {d0_if_en, d0_id_en, d0_exe_en, d0_mem_en, d0_wb_en, d0_id_rst,
                          d0_exe_rst, d0_mem_rst, d0_fwd_a, d0_fwd_b}, mon_e.o0);
            end
            n_cmp++;
            if (d1_stall_cnt !== mon_e.cnt || d0_stall_cnt !== mon_e.cnt) begin
                n_bad++;
                $display("FAIL stall_cnt cyc=%0d got=%0d/%0d want=%0d", cyc_no,
                         d1_stall_cnt, d0_stall_cnt, mon_e.cnt);
            end
        end
    end

    initial begin
        stim_t nop, s;
        logic  r;
        nop = mk(Y, 0, N, 0, N, N, 0, N, N, N);
        // Settle the DUT state with one unchecked reset edge.
        rst = 1'b0; id_valid = 1'b0; rs_addr = '0; rt_addr = '0; rs_used = 1'b0;
        rt_used = 1'b0; id_wen = 1'b0; id_waddr = '0; id_is_load = 1'b0;
        id_is_mc = 1'b0; id_is_branch = 1'b0; branch_taken = 1'b0;
        @(posedge clk); #1;

        drive(N, nop); #2;
        chk("rst_if_en", 32'(d1_if_en), 0);
        chk("rst_exe_rst", 32'(d1_exe_rst), 1);
        chk("rst_cnt", d1_stall_cnt, 0);
        tick();

        cyc(Y, mk(Y, 0, N, 0, N, Y, 3, N, N, N));                 // ADD r3
        drive(Y, mk(Y, 3, Y, 0, N, Y, 4, N, N, N)); #2;            // SUB rs=r3
        chk("alu_fwd_a", 32'(d1_fwd_a), 1);
        chk("alu_no_stall", 32'(d1_if_en), 1);
        tick();
        drive(Y, mk(N, 3, Y, 0, N, Y, 4, N, N, N)); #2;            // invalid ID reads r3
        chk("invalid_fwd_a", 32'(d1_fwd_a), 0);
        tick();

        cyc(Y, mk(Y, 0, N, 0, N, Y, 5, Y, N, N));                 // LW r5
        drive(Y, mk(Y, 0, N, 5, Y, Y, 6, N, N, N)); #2;            // ADD rt=r5
        chk("lu_if_en", 32'(d1_if_en), 0);
        chk("lu_exe_rst", 32'(d1_exe_rst), 1);
        chk("lu_cnt_before", d1_stall_cnt, 0);
        tick();
        drive(Y, mk(Y, 0, N, 5, Y, Y, 6, N, N, N)); #2;
        chk("lu_fwd_b", 32'(d1_fwd_b), 3);
        chk("lu_released", 32'(d1_if_en), 1);
        chk("lu_cnt_after", d1_stall_cnt, 1);
        tick();

        cyc(Y, mk(Y, 0, N, 0, N, Y, 0, Y, N, N));                 // LW r0
        drive(Y, mk(Y, 0, Y, 0, Y, Y, 8, N, N, N)); #2;
        chk("r0_no_stall", 32'(d1_if_en), 1);
        chk("r0_fwd_a", 32'(d1_fwd_a), 0);
        tick();

        cyc(Y, mk(Y, 0, N, 0, N, Y, 7, N, Y, N));                 // MUL r7
        for (int k = 0; k < LAT - 1; k++) begin
            drive(Y, nop); #2;
            chk("mc_exe_en", 32'(d1_exe_en), 0);
            chk("mc_mem_rst", 32'(d1_mem_rst), 1);
            tick();
        end
        drive(Y, nop); #2;
        chk("mc_done_exe_en", 32'(d1_exe_en), 1);
        chk("mc_cnt", d1_stall_cnt, 4);
        tick();

        drive(Y, mk(Y, 0, N, 0, N, N, 0, N, N, Y)); #2;            // taken branch, clean
        chk("br_ds0_flush", 32'(d0_id_rst), 1);
        chk("br_ds1_noflush", 32'(d1_id_rst), 0);
        tick();
        drive(Y, nop); #2;
        chk("br_one_cycle", 32'(d0_id_rst), 0);
        tick();

        cyc(Y, mk(Y, 0, N, 0, N, Y, 9, Y, N, N));                 // LW r9
        drive(Y, mk(Y, 9, Y, 0, N, N, 0, N, N, Y)); #2;            // branch on r9
        chk("brlu_no_flush", 32'(d0_id_rst), 0);
        chk("brlu_stall", 32'(d0_if_en), 0);
        tick();
        drive(Y, mk(Y, 9, Y, 0, N, N, 0, N, N, Y)); #2;
        chk("brlu_flush_after", 32'(d0_id_rst), 1);
        chk("brlu_fwd_a", 32'(d0_fwd_a), 3);
        tick();

        cyc(Y, mk(Y, 0, N, 0, N, Y, 7, N, Y, N));                 // MUL r7
        cyc(Y, nop);                                               // busy cycle 1
        drive(N, nop); #2;                                         // reset in busy cycle 2
        chk("rmo_in_reset", 32'(d1_exe_en), 0);
        tick();
        drive(Y, nop); #2;
        chk("rmo_if_en", 32'(d1_if_en), 1);
        chk("rmo_exe_en", 32'(d1_exe_en), 1);
        chk("rmo_cnt", d1_stall_cnt, 0);
        tick();

        for (int i = 0; i < 500; i++) begin
            s.v   = ($urandom_range(0, 7) != 0);
            s.rs  = 5'($urandom_range(0, 3));
            s.rsu = ($urandom_range(0, 3) != 0);
            s.rt  = 5'($urandom_range(0, 3));
            s.rtu = ($urandom_range(0, 1) != 0);
            s.wen = ($urandom_range(0, 4) != 0);
            s.wd  = 5'($urandom_range(0, 3));
            s.mc  = ($urandom_range(0, 11) == 0);
            s.ld  = !s.mc && ($urandom_range(0, 2) == 0);
            s.bt  = ($urandom_range(0, 3) == 0);
            r     = ($urandom_range(0, 59) != 0);
            cyc(r, s);
        end

        @(negedge clk); #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset, with the clock port named clk and the reset port named rst.
REQ-002 Parameters SHALL be (name, default, meaning):
- REG_AW, 5: register address width.
- MC_LAT, 4: EXE cycles taken by a multi-cycle op (minimum 2).
- DELAY_SLOT, 1: 1 = taken branch executes the delay slot; 0 = the fetched wrong-path instruction is squashed.
- CNT_W, 32: width of the stall counter.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-low reset.
- id_valid, in, 1: ID holds a real instruction.
- rs_addr / rt_addr, in, REG_AW: ID source registers.
- rs_used / rt_used, in, 1: each source is read.
- id_wen, in, 1: ID instruction writes a register.
- id_waddr, in, REG_AW: ID destination register.
- id_is_load, in, 1: ID instruction is a load.
- id_is_mc, in, 1: ID instruction is a multi-cycle EXE op.
- id_is_branch, in, 1: ID instruction compares or uses sources in ID (branch, JR).
- branch_taken, in, 1: ID resolved a taken branch or jump.
- if_en / id_en / exe_en / mem_en / wb_en, out, 1 each: stage enables.
- id_rst / exe_rst / mem_rst, out, 1 each: stage bubble or flush.
- fwd_a / fwd_b, out, 2 each: operand source. 0 = regfile, 1 = EXE ALU, 2 = MEM ALU, 3 = MEM load data.
- stall_cnt, out, CNT_W: total stall cycles.

Function
REQ-004 The block SHALL keep an internal scoreboard of {valid, wen, waddr, is_load} for EXE, MEM and WB, shifting the entries on each enabled edge.
REQ-005 A source SHALL match a stage only when all of these hold: the source is used, its address is nonzero, the stage entry is valid with wen = 1, and waddr equals the source address.
REQ-006 Forwarding SHALL give EXE priority over MEM, and MEM over WB/regfile. The code for a MEM match SHALL be 3 if the MEM entry is a load, otherwise 2.
REQ-007 A load-use stall SHALL be raised when a source matches EXE and the EXE entry is a load.
REQ-008 During a load-use stall, if_en and id_en SHALL be 0 and exe_rst SHALL be 1, so a bubble enters EXE; this SHALL last exactly one cycle.
REQ-009 A multi-cycle op entering EXE SHALL load a busy counter with MC_LAT-1.
REQ-010 While the busy counter is nonzero:
- if_en, id_en and exe_en SHALL be 0;
- mem_rst SHALL be 1;
- the counter SHALL decrement each cycle;
- the EXE scoreboard entry SHALL hold.
REQ-011 With DELAY_SLOT = 0, a branch_taken during a cycle that is not stalled SHALL assert id_rst for one cycle, squashing the instruction in IF.
REQ-012 With DELAY_SLOT = 1, branch_taken SHALL never flush.
REQ-013 Simultaneous events SHALL follow this priority: multi-cycle busy > load-use stall > branch flush. branch_taken SHALL be ignored while ID is stalled.
REQ-014 When id_valid = 0, the block SHALL suppress all ID hazards and force fwd to 0.
REQ-015 stall_cnt SHALL increment once per cycle in which if_en = 0 and rst = 1, and SHALL saturate at all-ones.
REQ-016 All enables default to 1 and all stage resets to 0 when there is no hazard.
REQ-017 Outputs SHALL be registered-state-derived combinational logic; there SHALL be no combinational path from branch_taken to fwd_a or fwd_b.

Reset
REQ-018 While rst = 0 at a clock edge, the block SHALL clear all of the following: scoreboard valid bits, the busy counter and stall_cnt.
REQ-019 While rst = 0, the outputs SHALL be: all enables 0, all stage resets 1, fwd_a = fwd_b = 0.
REQ-020 A reset asserted while a multi-cycle op is in progress SHALL abort the op, and the first cycle after release SHALL have no stall.

Structure
REQ-021 Forwarding codes, MC_LAT minimum and scoreboard entry type SHALL live in shared package mips_pipe_pkg.
REQ-022 Per-operand match and select logic SHALL be one sub-module, fwd_sel, instantiated twice (rs, rt).

Verification
REQ-023 ALU hazard: ADD r3 in EXE, then SUB with rs = r3 in ID -> fwd_a = 1, no stall.
REQ-024 Load-use: LW r5 in EXE, then ADD with rt = r5 in ID:
- first cycle: if_en = 0, exe_rst = 1, stall_cnt +1;
- next cycle: fwd_b = 3.
REQ-025 Register zero: LW r0, then a consumer of r0 -> no stall, fwd = 0.
REQ-026 Multi-cycle, MC_LAT = 4: a multi-cycle op in EXE -> exe_en = 0 for 3 cycles, mem_rst = 1 for 3 cycles, stall_cnt +3.
REQ-027 Branch: DELAY_SLOT = 0 with branch_taken in a clean cycle -> id_rst = 1 for one cycle. The same stimulus with DELAY_SLOT = 1 -> id_rst = 0.
REQ-028 Reset mid-op: rst = 0 in the 2nd busy cycle -> busy counter 0 and all enables 1 on the first cycle after release.
